// File: rtl/morse_tx_scheduler.sv
// morse_tx_scheduler
// Shares the Morse transmit path between N message sources. One source is
// granted at a time (round-robin); its payload is streamed into the transmit
// FIFO, ETX (8'h03) is appended, start_transmission is pulsed, and the grant
// is held until the transmitter has gone busy and returned to idle.
//
// Build option:
//   MORSE_TX_SCHED_PRIORITY_EN - when defined, req[0] wins arbitration
//   outright and the round-robin pointer only rotates over req[N-1:1].
//   A granted message is never preempted in either build.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req[N]                     per-source transmit request (level)
//   src_data[8N]               payload byte, source i on [8i+7:8i]
//   src_valid/src_last[N]      byte valid / final byte of message
//   src_ready[N]               byte accepted on valid & ready (granted bit only)
//   grant[N]                   registered one-hot grant
//   fifo_write, fifo_data[8]   transmit FIFO write port
//   fifo_full                  transmit FIFO full
//   start_transmission         one-cycle start pulse
//   transmission_in_progress   transmitter busy
//   busy                       scheduler not idle
//   message_done               one-cycle pulse after transmission completes
//   overflow                   one-cycle pulse when a message is truncated
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | no grant; arbitrate among requests
// S_LOAD      | copy granted source's payload bytes into the FIFO
// S_DRAIN     | payload hit MAX_LEN; discard remaining bytes until last
// S_ETX       | write the ETX terminator once the FIFO has room
// S_START     | start_transmission high for this single cycle
// S_WAIT_BUSY | wait for the transmitter to report busy
// S_WAIT_DONE | wait for the transmitter to go idle, then release grant
module morse_tx_scheduler #(
  parameter int N       = 4,
  parameter int MAX_LEN = 127
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] src_data,
  input  logic [N-1:0]   src_valid,
  input  logic [N-1:0]   src_last,
  output logic [N-1:0]   src_ready,
  output logic [N-1:0]   grant,
  output logic           fifo_write,
  output logic [7:0]     fifo_data,
  input  logic           fifo_full,
  output logic           start_transmission,
  input  logic           transmission_in_progress,
  output logic           busy,
  output logic           message_done,
  output logic           overflow
);

  localparam int            PW        = (N > 1) ? $clog2(N) : 1;
  localparam int            CW        = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_LEN_C = CW'(MAX_LEN);
  localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_LEN - 1);
  localparam logic [7:0]    ETX_BYTE  = 8'h03;
  localparam logic [N-1:0]  ONE       = N'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_ETX,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic          found;
  logic [CW-1:0] count;

  logic [7:0]    sel_data;
  logic          sel_valid;
  logic          sel_last;
  logic          sel_req;
  logic          room;
  logic          payload_byte;
  logic          accept_load;

  // Arbiter: each requester gets a distance from ptr+1 (with wrap); the
  // smallest distance wins, so the last winner ends up lowest priority.
  always_comb begin : arbiter
    int best;
    int d;
`ifdef MORSE_TX_SCHED_PRIORITY_EN
    int p;
`endif
    found   = 1'b0;
    win_idx = '0;
    best    = 2 * N;
    d       = 0;
`ifdef MORSE_TX_SCHED_PRIORITY_EN
    // ptr never points at source 0 in this build; treat 0 like N-1 anyway.
    p = (ptr == '0) ? (N - 1) : int'(ptr);
    if (req[0]) begin
      found   = 1'b1;
      win_idx = '0;
    end else begin
      for (int j = 1; j < N; j++) begin
        d = (j - p - 1 + 2 * (N - 1)) % (N - 1);
        if (req[j] && d < best) begin
          best    = d;
          win_idx = PW'(j);
          found   = 1'b1;
        end
      end
    end
`else
    for (int j = 0; j < N; j++) begin
      d = (j - int'(ptr) - 1 + 2 * N) % N;
      if (req[j] && d < best) begin
        best    = d;
        win_idx = PW'(j);
        found   = 1'b1;
      end
    end
`endif
  end

  // Mux the granted source's signals using the one-hot grant.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_req   = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (grant[j]) begin
        sel_data  = src_data[8*j +: 8];
        sel_valid = src_valid[j];
        sel_last  = src_last[j];
        sel_req   = req[j];
      end
    end
  end

  assign room         = !fifo_full && (count < MAX_LEN_C);
  assign payload_byte = (sel_data != ETX_BYTE);
  assign accept_load  = (state == S_LOAD) && room && sel_valid;
  assign busy         = (state != S_IDLE);

  // Write strobe is combinational so a byte lands in the FIFO in the very
  // cycle it is accepted, and fifo_full gates it with no lag.
  always_comb begin
    src_ready  = '0;
    fifo_write = 1'b0;
    fifo_data  = '0;
    case (state)
      S_LOAD: begin
        if (room) src_ready = grant;
        if (accept_load && payload_byte) begin
          fifo_write = 1'b1;
          fifo_data  = sel_data;
        end
      end
      S_DRAIN: src_ready = grant;
      S_ETX: begin
        if (!fifo_full) begin
          fifo_write = 1'b1;
          fifo_data  = ETX_BYTE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      grant              <= '0;
      ptr                <= PW'(N - 1);
      count              <= '0;
      start_transmission <= 1'b0;
      message_done       <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      start_transmission <= 1'b0;
      message_done       <= 1'b0;
      overflow           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant <= ONE << win_idx;
`ifdef MORSE_TX_SCHED_PRIORITY_EN
            if (!req[0]) ptr <= win_idx;
`else
            ptr <= win_idx;
`endif
            count <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept_load) begin
            if (payload_byte) count <= count + CW'(1);
            if (sel_last) begin
              state <= S_ETX;
            end else if (payload_byte && count == LAST_SLOT) begin
              state    <= S_DRAIN;
              overflow <= 1'b1;
            end
          end else if (!sel_req) begin
            // Abandoned message: send what we have, or just let go if empty.
            if (count != '0) begin
              state <= S_ETX;
            end else begin
              grant <= '0;
              state <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if ((sel_valid && sel_last) || !sel_req) state <= S_ETX;
        end
        S_ETX: begin
          if (!fifo_full) begin
            start_transmission <= 1'b1;
            state              <= S_START;
          end
        end
        S_START: state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (transmission_in_progress) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!transmission_in_progress) begin
            message_done <= 1'b1;
            grant        <= '0;
            count        <= '0;
            state        <= S_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Scoreboard bench for morse_tx_scheduler: stimulus pushes expected FIFO
// writes and grants into queues; a monitor pops and compares as the DUT
// produces them. Simple source agents and a transmitter model run alongside.
module tb_morse_tx_scheduler;
  localparam int N       = 4;
  localparam int MAX_LEN = 127;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] src_data;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_last;
  logic [N-1:0]   src_ready;
  logic [N-1:0]   grant;
  logic           fifo_write;
  logic [7:0]     fifo_data;
  logic           fifo_full;
  logic           start_transmission;
  logic           tip;
  logic           busy;
  logic           message_done;
  logic           overflow;

  morse_tx_scheduler #(.N(N), .MAX_LEN(MAX_LEN)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .req                      (req),
    .src_data                 (src_data),
    .src_valid                (src_valid),
    .src_last                 (src_last),
    .src_ready                (src_ready),
    .grant                    (grant),
    .fifo_write               (fifo_write),
    .fifo_data                (fifo_data),
    .fifo_full                (fifo_full),
    .start_transmission       (start_transmission),
    .transmission_in_progress (tip),
    .busy                     (busy),
    .message_done             (message_done),
    .overflow                 (overflow)
  );

  always #5 clk = ~clk;

  typedef logic [8:0] byte_q_t[$];
  byte_q_t sq [N];

  logic [7:0]   exp_wr[$];
  logic [N-1:0] exp_grant[$];

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int ovf_cnt = 0;
  int wr_seen = 0;
  int tip_len = 20;
  logic [N-1:0] req_force = '0;
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] acc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      if (sq[i].size() > 0) begin
        h = sq[i][0];
        src_valid[i]      = 1'b1;
        src_data[8*i +: 8] = h[7:0];
        src_last[i]       = h[8];
      end else begin
        src_valid[i]      = 1'b0;
        src_data[8*i +: 8] = 8'h00;
        src_last[i]       = 1'b0;
      end
      req[i] = (sq[i].size() > 0) || req_force[i];
    end
  endtask

  task automatic load_byte(input int s, input logic [7:0] b, input logic last);
    sq[s].push_back({last, b});
  endtask

  // Source agents: bytes handshaken at a negedge are retired after the edge.
  always @(negedge clk) acc = src_valid & src_ready;
  always @(posedge clk) begin
    logic [8:0] junk;
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && sq[i].size() > 0) junk = sq[i].pop_front();
    acc = '0;
    drive();
  end

  // Transmitter model: busy two cycles after start, for tip_len cycles.
  always begin
    @(negedge clk);
    if (rst_n && start_transmission) begin
      repeat (2) @(posedge clk);
      #2 tip = 1'b1;
      repeat (tip_len) @(posedge clk);
      #2 tip = 1'b0;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [7:0]   e;
    logic [N-1:0] g;
    if (rst_n) begin
      if (fifo_write) begin
        wr_seen++;
        check("write_while_full", {31'd0, fifo_full}, 32'd0);
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h expected none", fifo_data);
        end else begin
          e = exp_wr.pop_front();
          check("fifo_data", {24'd0, fifo_data}, {24'd0, e});
        end
      end
      if (grant != '0 && prev_grant == '0) begin
        check("grant_onehot", {31'd0, $onehot(grant)}, 32'd1);
        if (exp_grant.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got %0h expected none", grant);
        end else begin
          g = exp_grant.pop_front();
          check("grant_order", {28'd0, grant}, {28'd0, g});
        end
      end
      if (src_ready != '0) check("ready_outside_grant", {28'd0, src_ready & ~grant}, 32'd0);
      if (start_transmission) start_cnt++;
      if (message_done) done_cnt++;
      if (overflow) ovf_cnt++;
    end
    prev_grant = grant;
  end

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    tip       = 1'b0;
    req_force = '0;
    for (int i = 0; i < N; i++) sq[i].delete();
    drive();
    exp_wr.delete();
    exp_grant.delete();
    start_cnt = 0;
    done_cnt  = 0;
    ovf_cnt   = 0;
    wr_seen   = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic end_of_test(input string name);
    check({name, "_wr_queue_empty"}, exp_wr.size(), 32'd0);
    check({name, "_grant_queue_empty"}, exp_grant.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  hit;
    logic [7:0] b;
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    tip       = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_src_ready", {28'd0, src_ready}, 32'd0);
    check("rst_fifo_write", {31'd0, fifo_write}, 32'd0);
    check("rst_fifo_data", {24'd0, fifo_data}, 32'd0);
    check("rst_start", {31'd0, start_transmission}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, message_done}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Test 1: source 1 sends "SOS".
    @(posedge clk);
    #2;
    tip_len = 20;
    exp_grant.push_back(4'b0010);
    exp_wr.push_back(8'h53); exp_wr.push_back(8'h4F);
    exp_wr.push_back(8'h53); exp_wr.push_back(8'h03);
    load_byte(1, 8'h53, 1'b0);
    load_byte(1, 8'h4F, 1'b0);
    load_byte(1, 8'h53, 1'b1);
    drive();
    @(negedge clk);
    check("t1_grant_not_early", {28'd0, grant}, 32'd0);
    @(negedge clk);
    check("t1_grant_latency", {28'd0, grant}, 32'h2);
    wait_done(1, 200, "t1_done_seen");
    check("t1_done_pulse", {31'd0, message_done}, 32'd1);
    check("t1_grant_released", {28'd0, grant}, 32'd0);
    check("t1_start_count", start_cnt, 32'd1);
    end_of_test("t1");

    // Test 2: all four request; source 0 has a second message queued.
    do_reset();
    @(posedge clk);
    #2;
    tip_len = 3;
`ifdef MORSE_TX_SCHED_PRIORITY_EN
    exp_grant.push_back(4'b0001); exp_grant.push_back(4'b0001);
    exp_grant.push_back(4'b0010); exp_grant.push_back(4'b0100);
    exp_grant.push_back(4'b1000);
    exp_wr.push_back(8'h10); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h14); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h11); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h12); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h13); exp_wr.push_back(8'h03);
`else
    exp_grant.push_back(4'b0001); exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b0100); exp_grant.push_back(4'b1000);
    exp_grant.push_back(4'b0001);
    exp_wr.push_back(8'h10); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h11); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h12); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h13); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h14); exp_wr.push_back(8'h03);
`endif
    load_byte(0, 8'h10, 1'b1);
    load_byte(0, 8'h14, 1'b1);
    load_byte(1, 8'h11, 1'b1);
    load_byte(2, 8'h12, 1'b1);
    load_byte(3, 8'h13, 1'b1);
    drive();
    wait_done(5, 400, "t2_done_seen");
    check("t2_start_count", start_cnt, 32'd5);
    repeat (3) @(negedge clk);
    check("t2_idle_after", {31'd0, busy}, 32'd0);
    end_of_test("t2");

    // Test 3: source 2 streams 130 bytes; 127 kept, 3 discarded.
    do_reset();
    @(posedge clk);
    #2;
    tip_len = 3;
    exp_grant.push_back(4'b0100);
    for (int i = 0; i < 130; i++) begin
      b = 8'h40 + 8'(i % 32);
      load_byte(2, b, (i == 129));
      if (i < MAX_LEN) exp_wr.push_back(b);
    end
    exp_wr.push_back(8'h03);
    drive();
    wait_done(1, 800, "t3_done_seen");
    check("t3_overflow_count", ovf_cnt, 32'd1);
    check("t3_start_count", start_cnt, 32'd1);
    check("t3_all_bytes_consumed", sq[2].size(), 32'd0);
    check("t3_write_count", wr_seen, 32'd128);
    end_of_test("t3");

    // Test 4: fifo_full stalls mid-LOAD and in ETX.
    do_reset();
    @(posedge clk);
    #2;
    tip_len = 3;
    exp_grant.push_back(4'b1000);
    load_byte(3, 8'h48, 1'b0); exp_wr.push_back(8'h48);
    load_byte(3, 8'h45, 1'b0); exp_wr.push_back(8'h45);
    load_byte(3, 8'h4C, 1'b0); exp_wr.push_back(8'h4C);
    load_byte(3, 8'h4C, 1'b0); exp_wr.push_back(8'h4C);
    load_byte(3, 8'h4F, 1'b0); exp_wr.push_back(8'h4F);
    load_byte(3, 8'h21, 1'b1); exp_wr.push_back(8'h21);
    exp_wr.push_back(8'h03);
    drive();
    k = 0;
    while (wr_seen < 2 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("t4_reached_mid_load", {31'd0, wr_seen >= 2}, 32'd1);
    @(posedge clk);
    #2 fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_load_stall_ready", {28'd0, src_ready}, 32'd0);
      check("t4_load_stall_write", {31'd0, fifo_write}, 32'd0);
    end
    @(posedge clk);
    #2 fifo_full = 1'b0;
    k   = 0;
    hit = 1'b0;
    while (!hit && k < 50) begin
      @(negedge clk);
      #1;
      hit = src_valid[3] && src_last[3] && src_ready[3];
      k++;
    end
    check("t4_last_accepted", {31'd0, hit}, 32'd1);
    @(posedge clk);
    #2 fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_etx_stall_write", {31'd0, fifo_write}, 32'd0);
      check("t4_etx_stall_start", {31'd0, start_transmission}, 32'd0);
    end
    @(posedge clk);
    #2 fifo_full = 1'b0;
    wait_done(1, 100, "t4_done_seen");
    check("t4_start_count", start_cnt, 32'd1);
    check("t4_write_count", wr_seen, 32'd7);
    end_of_test("t4");

    // Test 5: source 0 abandons with no data; source 3 sends "A\x03B".
    do_reset();
    @(posedge clk);
    #2;
    tip_len = 3;
    exp_grant.push_back(4'b0001);
    exp_grant.push_back(4'b1000);
    exp_wr.push_back(8'h41); exp_wr.push_back(8'h42); exp_wr.push_back(8'h03);
    req_force[0] = 1'b1;
    load_byte(3, 8'h41, 1'b0);
    load_byte(3, 8'h03, 1'b0);
    load_byte(3, 8'h42, 1'b1);
    drive();
    @(negedge clk);
    @(negedge clk);
    check("t5_grant_src0", {28'd0, grant}, 32'h1);
    @(posedge clk);
    #2;
    req_force[0] = 1'b0;
    drive();
    @(negedge clk);
    @(negedge clk);
    check("t5_abandon_release", {28'd0, grant}, 32'd0);
    check("t5_abandon_idle", {31'd0, busy}, 32'd0);
    check("t5_abandon_no_start", start_cnt, 32'd0);
    wait_done(1, 100, "t5_done_seen");
    check("t5_start_count", start_cnt, 32'd1);
    check("t5_write_count", wr_seen, 32'd3);
    end_of_test("t5");

    // Test 6: sources 1..3 request; source 0 arrives during source 1's wait.
    do_reset();
    @(posedge clk);
    #2;
    tip_len = 6;
`ifdef MORSE_TX_SCHED_PRIORITY_EN
    exp_grant.push_back(4'b0010); exp_grant.push_back(4'b0001);
    exp_grant.push_back(4'b0100); exp_grant.push_back(4'b1000);
    exp_wr.push_back(8'h61); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h60); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h62); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h63); exp_wr.push_back(8'h03);
`else
    exp_grant.push_back(4'b0010); exp_grant.push_back(4'b0100);
    exp_grant.push_back(4'b1000); exp_grant.push_back(4'b0001);
    exp_wr.push_back(8'h61); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h62); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h63); exp_wr.push_back(8'h03);
    exp_wr.push_back(8'h60); exp_wr.push_back(8'h03);
`endif
    load_byte(1, 8'h61, 1'b1);
    load_byte(2, 8'h62, 1'b1);
    load_byte(3, 8'h63, 1'b1);
    drive();
    k = 0;
    while (!tip && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("t6_first_transmit", {31'd0, tip}, 32'd1);
    @(posedge clk);
    #2;
    load_byte(0, 8'h60, 1'b1);
    drive();
    wait_done(4, 300, "t6_done_seen");
    check("t6_start_count", start_cnt, 32'd4);
    end_of_test("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_tx_scheduler.md
Name: morse_tx_scheduler

Overview:
- Shares the Morse transceiver's transmit path between N independent message sources (CPU mailbox, beacon generator, auto-reply, ...).
- Grants one requester at a time, round-robin. Streams the winner's bytes into the 128-entry transmit FIFO, appends ETX (8'h03), pulses start_transmission, then holds the grant until the transmitter reports idle.
- Sits between the message sources and the transceiver's transmit FIFO write port / start_transmission / transmission_in_progress signals.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_LEN, 127, max payload bytes per message; leaves one FIFO slot for ETX.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  per-source transmit request (level).
- src_data  in  8*N  payload byte; source i uses bits [8i+7:8i].
- src_valid  in  N  src_data valid.
- src_last  in  N  final payload byte of the message.
- src_ready  out  N  byte accepted when src_valid & src_ready; only the granted bit can be 1.
- grant  out  N  one-hot grant, registered.
- fifo_write  out  1  transmit FIFO write strobe.
- fifo_data  out  8  transmit FIFO write data.
- fifo_full  in  1  transmit FIFO full.
- start_transmission  out  1  one-cycle start pulse.
- transmission_in_progress  in  1  transmitter busy.
- busy  out  1  scheduler not in IDLE.
- message_done  out  1  one-cycle pulse when a message has completed transmission.
- overflow  out  1  one-cycle pulse when a message is truncated.

Behaviour:
- Reset: state IDLE; grant=0, src_ready=0, fifo_write=0, fifo_data=0, start_transmission=0, busy=0, message_done=0, overflow=0, byte count=0, round-robin pointer=N-1.
- IDLE:
  - If req!=0, the winner is the first set req bit searching upward (with wrap) from pointer+1.
  - grant is registered the next cycle; pointer is updated to the winner.
  - Go to LOAD.
- LOAD:
  - src_ready[g] = !fifo_full && count<MAX_LEN (combinational).
  - Accepted byte != 8'h03: fifo_write=1, fifo_data=byte, count+1, all in the same cycle.
  - Accepted byte == 8'h03: consumed but dropped; no write, count unchanged.
  - Accepted with src_last → ETX.
  - count reaches MAX_LEN without last → DRAIN.
  - req[g] falls before last: if count>0 → ETX; if count==0 → release grant, return to IDLE, no FIFO writes and no start.
- DRAIN:
  - src_ready[g]=1; bytes are discarded until last is accepted (or req[g] falls).
  - Pulse overflow once on entry; → ETX.
- ETX: when !fifo_full, write 8'h03 → START.
- START: start_transmission=1 for exactly one cycle → WAIT_BUSY.
- WAIT_BUSY: wait for transmission_in_progress=1 → WAIT_DONE.
- WAIT_DONE: when transmission_in_progress=0: message_done pulse, grant=0, count=0 → IDLE.
- grant is held constant from LOAD through WAIT_DONE. Requests from other sources are ignored until IDLE; no preemption.
- fifo_full during LOAD or ETX stalls the state with no write; never write while full.
- Simultaneous req in IDLE: pure round-robin. A source that just finished is lowest priority next round.
- busy = (state != IDLE).
- Reset mid-message: immediate return to IDLE. Partial FIFO contents are not flushed by this block.
- Minimum latency, req to first fifo_write: 2 cycles (IDLE→grant, then LOAD accept).

Optional Feature:
- MORSE_TX_SCHED_PRIORITY_EN defined:
  - req[0] has strict priority in IDLE; the round-robin pointer applies only among req[N-1:1].
  - Still no preemption of a granted message.
- Undefined: pure round-robin over all N requesters.

Test Plan:
- Reset release, req=4'b0010, source 1 sends "SOS" (3 bytes, last on 'S') → grant=4'b0010 one cycle after req; fifo writes 8'h53,8'h4F,8'h53,8'h03; one start_transmission pulse; TIP high 20 cycles then low → message_done pulse, grant=0.
- req=4'b1111 held, each source sends 1 byte, repeated → grant order 0,1,2,3,0; each source gets exactly one message before any repeats.
- Source 2 streams 130 bytes, MAX_LEN=127 → 127 payload writes, overflow pulse, remaining 3 bytes accepted and discarded, ETX written, single start.
- fifo_full forced high for 5 cycles mid-LOAD and during ETX → src_ready=0 and fifo_write=0 throughout; no byte lost or duplicated after release.
- Source 0 drops req with no byte sent → grant returns to 0, no fifo_write, no start_transmission; source 3 pending is granted next. Byte 8'h03 inside a payload "A\x03B" → only 8'h41,8'h42,8'h03 are written.
- With MORSE_TX_SCHED_PRIORITY_EN, req=4'b1110 then req[0] rises during source 1's WAIT_DONE → source 1 completes, next grant=4'b0001 even though the pointer favours source 2.
